bus_master_port: RTL

- Initiator-side bus interface that drives the 4-entry register peripheral bus (wr_en, rd_en, addr, wdata, rdata).
- Buffers host commands in a small FIFO and requests the shared bus from the multi-peripheral arbiter (bus_req/bus_gnt).
- Issues single-cycle write or read strobes and returns read data to the host over a valid/ready response channel.

---
 rtl/bus_master_port.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/bus_master_port.sv
// bus_master_port: the initiator side of the 4-entry register peripheral bus.
// Host commands are queued in a small FIFO. The port then requests the shared
// bus from the arbiter, issues one single-cycle write or read strobe per
// command, and returns read data over a response channel.
//
// Handshake semantics (both host channels): a transfer happens on the rising
// clk edge where valid && ready are both 1. A valid source holds its payload
// stable and keeps valid high until that edge. ready may change freely and
// never depends combinationally on valid.
//
// Bus side: wr_en/rd_en/addr/wdata are decoded only from registered state, so
// there is no combinational path from cmd_* or rsp_ready to the bus.
module bus_master_port #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 2,
  parameter int DATA_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  // host command channel
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  // host response channel
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] rsp_addr,
  // arbiter
  output logic              bus_req,
  input  logic              bus_gnt,
  // peripheral bus
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  // debug: current FSM state (0 IDLE, 1 REQ, 2 ISSUE, 3 CAPTURE, 4 RESP)
  output logic [2:0]        dbg_state
);

  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int ENTRY_W = 1 + ADDR_W + DATA_W;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_ISSUE   = 3'd2,
    S_CAPTURE = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t state, next_state;

  // ---------------------------------------------------------------------------
  // Command FIFO: entry = {we, addr, wdata}
  // ---------------------------------------------------------------------------
  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;

  logic [ENTRY_W-1:0] head;
  logic               head_we;
  logic [ADDR_W-1:0]  head_addr;
  logic [DATA_W-1:0]  head_wdata;

  // Address of the read being issued, kept for the response.
  logic [ADDR_W-1:0]  rd_addr_q;

  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = !full;

  // A full FIFO refuses the push even in the cycle that pops it.
  assign push = cmd_valid && !full;
  // ISSUE is only ever entered with a valid head, so the pop is unconditional.
  assign pop  = (state == S_ISSUE);

  assign count_next = count + CNT_W'(push) - CNT_W'(pop);

  assign head       = mem[rd_ptr];
  assign head_we    = head[ENTRY_W-1];
  assign head_addr  = head[DATA_W +: ADDR_W];
  assign head_wdata = head[DATA_W-1:0];

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_we, cmd_addr, cmd_wdata};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (power-of-2 depth).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state logic. bus_gnt matters only in REQ and at the end of a write
  // ISSUE; the arbiter never revokes a grant while bus_req is high.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (!empty) next_state = S_REQ;
      S_REQ:     if (bus_gnt) next_state = S_ISSUE;
      S_ISSUE: begin
        if (!head_we)                            next_state = S_CAPTURE;
        else if ((count_next != '0) && bus_gnt)  next_state = S_ISSUE;
        else                                     next_state = S_IDLE;
      end
      S_CAPTURE: next_state = S_RESP;
      S_RESP:    if (rsp_ready) next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  // Output decode: bus strobes and address/data only during ISSUE, else 0.
  always_comb begin
    wr_en = 1'b0;
    rd_en = 1'b0;
    addr  = '0;
    wdata = '0;
    if (state == S_ISSUE) begin
      wr_en = head_we;
      rd_en = !head_we;
      addr  = head_addr;
      wdata = head_wdata;
    end
  end

  assign dbg_state = state;

  // bus_req is a flop that follows the upcoming state: high in REQ/ISSUE/CAPTURE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_req <= 1'b0;
    end else begin
      bus_req <= (next_state == S_REQ) || (next_state == S_ISSUE) ||
                 (next_state == S_CAPTURE);
    end
  end

  // Remember the read address at ISSUE so the response can report it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr_q <= '0;
    end else if ((state == S_ISSUE) && !head_we) begin
      rd_addr_q <= head_addr;
    end
  end

  // Response register: capture peripheral data at the end of CAPTURE and hold
  // it until the host takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_addr  <= '0;
    end else if (state == S_CAPTURE) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= rdata;
      rsp_addr  <= rd_addr_q;
    end else if ((state == S_RESP) && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
